pc_seq_ctrl: RTL and testbench
==============================

// Module: pc_seq_ctrl
// PURPOSE
//  Multi-cycle fetch/PC sequencer for the RISC-V core.
//  - Fetches each instruction from instruction memory over a req/ack handshake.
//  - Presents the instruction to decode, which feeds the immediate generator.
//  - Uses the returned immediate, plus the branch/JALR resolution from execute, to pick the next PC.
//  - Sits between instruction memory and the decode/immediate-generation stage.
// PARAMETERS
//  RESET_PC     32'h0000_0000  PC loaded on reset.
//  ACK_TIMEOUT  16             Max wait cycles in FETCH for imem_ack before error (1..255).
// PORTS
//  clk          in   1   Core clock; all state changes on rising edge.
//  reset        in   1   Asynchronous, active-low reset.
//  imem_req     out  1   Fetch request; held until imem_ack.
//  imem_addr    out  32  Fetch address (= pc_out).
//  imem_ack     in   1   Memory returns imem_rdata this cycle.
//  imem_rdata   in   32  Fetched instruction word.
//  inst_valid   out  1   inst_out/inst_pc valid to decode.
//  inst_ready   in   1   Decode accepts the instruction.
//  stall        in   1   Hazard hold; blocks acceptance in HOLD.
//  inst_out     out  32  Latched instruction (drives immediate generator input).
//  inst_pc      out  32  PC of inst_out.
//  imm_in       in   32  Immediate generator output for inst_out (combinational).
//  br_valid     in   1   Execute resolution valid for the held B-type/JALR.
//  br_taken     in   1   Branch condition result; qualified by br_valid.
//  jalr_target  in   32  rs1+imm from ALU; qualified by br_valid.
//  pc_out       out  32  Current fetch PC.
//  flush        out  1   1-cycle pulse on non-sequential redirect.
//  err          out  2   Sticky: 00 ok, 01 misaligned target, 10 fetch timeout.
//  retired_cnt  out  32  Instructions accepted by decode (feature-gated).
//  redirect_cnt out  32  Taken redirects (feature-gated).
// BEHAVIOUR
//  Reset (async, reset==0):
//  - State=IDLE, pc_out=RESET_PC.
//  - inst_out=0, inst_pc=0, err=0, wait counter=0.
//  - imem_req=0, inst_valid=0, flush=0, counters=0.
//  - Outputs drop immediately, including mid-fetch; an in-flight ack is ignored.
//  FSM states: IDLE, FETCH, HOLD, RESOLVE, HALT.
//  IDLE:
//  - Goes to FETCH on the first clock after reset deasserts.
//  FETCH:
//  - imem_req=1, imem_addr=pc_out; counter increments each cycle without an ack.
//  - On imem_ack: latch inst_out=imem_rdata, inst_pc=pc_out, clear counter, go to HOLD.
//  - If counter reaches ACK_TIMEOUT with no ack: err=10, go to HALT.
//  - Ack in the same cycle the counter reaches ACK_TIMEOUT: the ack wins.
//  HOLD:
//  - inst_valid=1. An instruction is accepted when inst_ready=1 && stall=0.
//  - stall has priority over inst_ready.
//  - On acceptance, by opcode inst_out[6:0]:
//    - 1101111 (JAL): next=inst_pc+imm_in; flush=1; go to FETCH.
//    - 1100011 (B) / 1100111 (JALR): go to RESOLVE; inst_valid drops.
//    - Otherwise: next=inst_pc+4, no flush; go to FETCH.
//  RESOLVE:
//  - Wait for br_valid; inst_out is held so imm_in stays stable.
//  - B: taken -> next=inst_pc+imm_in, flush=1; not taken -> next=inst_pc+4.
//  - JALR: next={jalr_target[31:1],1'b0}, flush=1.
//  - br_valid in any other state is ignored.
//  Redirect check:
//  - Any next PC with next[1:0]!=0: err=01, pc_out unchanged, go to HALT.
//  - Otherwise pc_out=next at the transition to FETCH.
//  HALT:
//  - Terminal until reset. All handshake outputs are 0.
//  - err, pc_out and inst_pc are held.
//  Arithmetic: 32-bit unsigned adds, wrap modulo 2^32 (0xFFFF_FFFC+4 -> 0).
//  Latency:
//  - Sequential instruction: ack -> next imem_req = 2 cycles minimum (HOLD, then FETCH).
//  - Branch/JALR: ack -> next imem_req = 3 cycles minimum (HOLD, RESOLVE, then FETCH).
// CONFIGURATION
//  PC_SEQ_PERF_EN defined:
//  - retired_cnt increments on each decode acceptance.
//  - redirect_cnt increments on each flush pulse.
//  - Both wrap modulo 2^32; both are cleared only by reset.
//  PC_SEQ_PERF_EN undefined:
//  - Ports remain, both tied to 32'h0; no counter flops.
// TESTING
//  1. Reset, RESET_PC=0x100; imem acks in 1 cycle with ADDI words -> imem_addr 0x100,0x104,0x108; flush never 1.
//  2. JAL at 0x200, imm_in=0x40 -> next imem_addr=0x240, flush=1 for 1 cycle, redirect_cnt=1 (PERF on).
//  3. BEQ at 0x300, imm_in=0xFFFFFFF0: br_valid+taken -> 0x2F0 + flush; repeat not taken -> 0x304, no flush.
//  4. JALR with jalr_target=0x1235 -> pc 0x1234; jalr_target=0x1236 -> err=01, HALT, imem_req stays 0.
//  5. No imem_ack for 16 cycles (ACK_TIMEOUT=16) -> err=10, HALT; ack on cycle 16 instead -> normal HOLD.
//  6. Hold stall=1, inst_ready=1 for 5 cycles in HOLD -> no advance; reset asserted mid-FETCH -> imem_req=0 at once, pc=RESET_PC.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/PC sequencer: imem req/ack fetch, decode hand-off, branch/JALR redirect.
// Optional perf counters (retired/redirect) are built only when PC_SEQ_PERF_EN is defined.
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  input  logic        stall_i,
  output logic [31:0] inst_out_o,
  output logic [31:0] inst_pc_o,
  input  logic [31:0] imm_in_i,
  input  logic        br_valid_i,
  input  logic        br_taken_i,
  input  logic [31:0] jalr_target_i,
  output logic [31:0] pc_out_o,
  output logic        flush_o,
  output logic [1:0]  err_o,
  output logic [31:0] retired_cnt_o,
  output logic [31:0] redirect_cnt_o
);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, RESOLVE, HALT} state_t;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  wait_q, wait_d;

  logic [31:0] next_pc;
  logic        go;
  logic        nonseq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      err_q     <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      err_q     <= err_d;
      wait_q    <= wait_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    err_d        = err_q;
    wait_d       = wait_q;
    imem_req_o   = 1'b0;
    inst_valid_o = 1'b0;
    flush_o      = 1'b0;
    next_pc      = inst_pc_q + 32'd4;
    go           = 1'b0;
    nonseq       = 1'b0;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req_o = 1'b1;
        // An ack arriving on the final allowed cycle still completes the fetch.
        if (imem_ack_i) begin
          inst_d    = imem_rdata_i;
          inst_pc_d = pc_q;
          wait_d    = '0;
          state_d   = HOLD;
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = wait_q + 8'd1;
          err_d   = 2'b10;
          state_d = HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      HOLD: begin
        inst_valid_o = 1'b1;
        if (inst_ready_i && !stall_i) begin
          case (inst_q[6:0])
            OP_JAL: begin
              next_pc = inst_pc_q + imm_in_i;
              nonseq  = 1'b1;
              go      = 1'b1;
            end
            OP_B, OP_JALR: state_d = RESOLVE;
            default: go = 1'b1;
          endcase
        end
      end
      RESOLVE: begin
        if (br_valid_i) begin
          go = 1'b1;
          if (inst_q[6:0] == OP_JALR) begin
            next_pc = jalr_target_i & 32'hFFFF_FFFE;
            nonseq  = 1'b1;
          end else if (br_taken_i) begin
            next_pc = inst_pc_q + imm_in_i;
            nonseq  = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A misaligned target halts without touching the PC or signalling a flush.
    if (go) begin
      if (next_pc[1:0] != 2'b00) begin
        err_d   = 2'b01;
        state_d = HALT;
      end else begin
        pc_d    = next_pc;
        state_d = FETCH;
        flush_o = nonseq;
      end
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_out_o    = pc_q;
  assign inst_out_o  = inst_q;
  assign inst_pc_o   = inst_pc_q;
  assign err_o       = err_q;

`ifdef PC_SEQ_PERF_EN
  logic [31:0] retired_q, redirect_q;
  logic        accept;

  assign accept = (state_q == HOLD) && inst_ready_i && !stall_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q  <= '0;
      redirect_q <= '0;
    end else begin
      if (accept)  retired_q  <= retired_q + 32'd1;
      if (flush_o) redirect_q <= redirect_q + 32'd1;
    end
  end

  assign retired_cnt_o  = retired_q;
  assign redirect_cnt_o = redirect_q;
`else
  assign retired_cnt_o  = 32'h0;
  assign redirect_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Scoreboard bench for pc_seq_ctrl: expected fetch addresses/flush counts are queued by
// the stimulus and checked by a monitor on every imem handshake.
module tb_pc_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, inst_valid, inst_ready, stall;
  logic        br_valid, br_taken, flush;
  logic [31:0] imem_addr, imem_rdata, inst_out, inst_pc, imm_in, jalr_target, pc_out;
  logic [31:0] retired_cnt, redirect_cnt;
  logic [1:0]  err;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JALR = 32'h0000_0067;

  typedef struct {
    logic [31:0] addr;
    int          flushes;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   flush_cnt = 0;

  pc_seq_ctrl #(.RESET_PC(32'h0000_0100), .ACK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack), .imem_rdata_i(imem_rdata),
    .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .stall_i(stall),
    .inst_out_o(inst_out), .inst_pc_o(inst_pc), .imm_in_i(imm_in),
    .br_valid_i(br_valid), .br_taken_i(br_taken), .jalr_target_i(jalr_target),
    .pc_out_o(pc_out), .flush_o(flush), .err_o(err),
    .retired_cnt_o(retired_cnt), .redirect_cnt_o(redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: count flush pulses between fetches, check each handshake against the queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      flush_cnt = 0;
    end else begin
      if (flush) flush_cnt++;
      if (imem_req && imem_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fetch", imem_addr, 32'hxxxx_xxxx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_addr", imem_addr, e.addr);
          chk("flush_pulses", 32'(flush_cnt), 32'(e.flushes));
          $display("fetch addr=%h flushes=%0d", imem_addr, flush_cnt);
        end
        flush_cnt = 0;
      end
    end
  end

  task automatic push(input logic [31:0] a, input int f);
    exp_t e;
    e.addr = a;
    e.flushes = f;
    exp_q.push_back(e);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_timeout", {31'b0, imem_req}, 32'd1);
  endtask

  task automatic fetch(input logic [31:0] word, input int delay);
    wait_req();
    repeat (delay) begin
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("inst_out", inst_out, word);
  endtask

  task automatic accept(input logic [31:0] imm);
    chk("hold_valid", {31'b0, inst_valid}, 32'd1);
    imm_in = imm;
    inst_ready = 1'b1;
    stall = 1'b0;
    @(posedge clk); #1;
    inst_ready = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] tgt);
    chk("resolve_valid", {31'b0, inst_valid}, 32'd0);
    chk("resolve_req", {31'b0, imem_req}, 32'd0);
    br_valid = 1'b1;
    br_taken = taken;
    jalr_target = tgt;
    @(posedge clk); #1;
    br_valid = 1'b0;
  endtask

  function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef PC_SEQ_PERF_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; inst_ready = 1'b0; stall = 1'b0;
    imm_in = '0; br_valid = 1'b0; br_taken = 1'b0; jalr_target = '0;
    repeat (3) @(posedge clk); #1;
    chk("rst_pc", pc_out, 32'h100);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_err", {30'b0, err}, 32'd0);
    chk("rst_inst", inst_out, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    chk("rst_redirect", redirect_cnt, 32'd0);
    rst_n = 1'b1;

    // Sequential ADDI stream
    push(32'h100, 0); fetch(ADDI, 0); chk("inst_pc", inst_pc, 32'h100); accept(32'h0);
    push(32'h104, 0); fetch(ADDI, 1); accept(32'h0);
    push(32'h108, 0); fetch(ADDI, 0); accept(32'h0);
    // JAL chain to 0x200, then 0x240, then 0x300
    push(32'h10C, 0); fetch(JAL, 0); accept(32'h0000_00F4);
    chk("redirect_cnt_1", redirect_cnt, perf(32'd1));
    push(32'h200, 1); fetch(JAL, 0); accept(32'h0000_0040);
    push(32'h240, 1); fetch(JAL, 0); accept(32'h0000_00C0);
    // BEQ taken backward, back via JAL, then BEQ not taken
    push(32'h300, 1); fetch(BEQ, 0); accept(32'hFFFF_FFF0); resolve(1'b1, 32'h0);
    push(32'h2F0, 1); fetch(JAL, 0); accept(32'h0000_0010);
    push(32'h300, 1); fetch(BEQ, 0); accept(32'hFFFF_FFF0); resolve(1'b0, 32'h0);
    // Stall dominates inst_ready for 5 cycles
    push(32'h304, 0); fetch(ADDI, 0);
    stall = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0; inst_ready = 1'b0;
    accept(32'h0);
    // JALR clears bit 0; then late ack on cycle 16 and a misaligned JALR target
    push(32'h308, 0); fetch(JALR, 0); accept(32'h0); resolve(1'b0, 32'h0000_1235);
    push(32'h1234, 1); fetch(JALR, 15); chk("late_ack_pc", inst_pc, 32'h1234);
    accept(32'h0); resolve(1'b0, 32'h0000_1236);
    chk("misalign_err", {30'b0, err}, 32'd1);
    repeat (4) @(posedge clk); #1;
    chk("halt_req", {31'b0, imem_req}, 32'd0);
    chk("halt_valid", {31'b0, inst_valid}, 32'd0);
    chk("halt_pc", pc_out, 32'h1234);
    chk("halt_inst_pc", inst_pc, 32'h1234);
    chk("halt_err", {30'b0, err}, 32'd1);
    chk("retired_cnt", retired_cnt, perf(32'd12));
    chk("redirect_cnt", redirect_cnt, perf(32'd6));

    // Fetch timeout: no ack for 16 request cycles
    rst_n = 1'b0; #1;
    chk("rst2_err", {30'b0, err}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;
    wait_req();
    repeat (15) @(posedge clk); #1;
    chk("req_cycle16", {31'b0, imem_req}, 32'd1);
    @(posedge clk); #1;
    chk("timeout_req", {31'b0, imem_req}, 32'd0);
    chk("timeout_err", {30'b0, err}, 32'd2);

    // Reset asserted mid-FETCH drops outputs immediately
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    wait_req();
    @(posedge clk); #3;
    imem_ack = 1'b1;
    rst_n = 1'b0; #1;
    chk("async_req", {31'b0, imem_req}, 32'd0);
    chk("async_pc", pc_out, 32'h100);
    chk("async_err", {30'b0, err}, 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("async_inst", inst_out, 32'd0);
    rst_n = 1'b1;

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
